// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the ALU execution unit: datapath width, RoB index
// width, dispatched op encodings and the branch-compare helper.
package alu_exec_unit_pkg;

  localparam int XLEN       = 32;
  localparam int ROB_ADDR_W = 4;

  typedef enum logic [5:0] {
    ALU_NONE = 6'd0,
    ALU_ADD  = 6'd1,
    ALU_SUB  = 6'd2,
    ALU_AND  = 6'd3,
    ALU_OR   = 6'd4,
    ALU_XOR  = 6'd5,
    ALU_SLL  = 6'd6,
    ALU_SRL  = 6'd7,
    ALU_SRA  = 6'd8,
    ALU_SLT  = 6'd9,
    ALU_SLTU = 6'd10,
    ALU_LUI  = 6'd11,
    ALU_BEQ  = 6'd12,
    ALU_BNE  = 6'd13,
    ALU_BLT  = 6'd14,
    ALU_BGE  = 6'd15,
    ALU_BLTU = 6'd16,
    ALU_BGEU = 6'd17
  } alu_op_e;

  // Branch condition evaluation; returns 0 for any non-branch op.
  function automatic logic br_taken(input logic [5:0] op,
                                    input logic signed [XLEN-1:0] a,
                                    input logic signed [XLEN-1:0] b);
    logic taken;
    taken = 1'b0;
    case (op)
      ALU_BEQ:  taken = (a == b);
      ALU_BNE:  taken = (a != b);
      ALU_BLT:  taken = (a < b);
      ALU_BGE:  taken = (a >= b);
      ALU_BLTU: taken = ($unsigned(a) < $unsigned(b));
      ALU_BGEU: taken = ($unsigned(a) >= $unsigned(b));
      default:  taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Dispatch bus (reservation station -> ALU) and result broadcast bus
// (ALU -> RS / LSB / RoB) bundled together.
interface alu_exec_unit_if
  import alu_exec_unit_pkg::*;
#(
  parameter int ROB_W = ROB_ADDR_W
);
  logic [5:0]      alu_op;
  logic [XLEN-1:0] alu_rs1;
  logic [XLEN-1:0] alu_rs2;
  logic [ROB_W-1:0] alu_id;
  logic            alu_valid;
  logic [ROB_W-1:0] alu_robid;
  logic [XLEN-1:0] alu_val;
  logic            alu_is_br;

  modport master (
    output alu_op, alu_rs1, alu_rs2, alu_id,
    input  alu_valid, alu_robid, alu_val, alu_is_br
  );

  modport slave (
    input  alu_op, alu_rs1, alu_rs2, alu_id,
    output alu_valid, alu_robid, alu_val, alu_is_br
  );
endinterface

// File: rtl/alu_exec_unit_compute.sv
// Purely combinational RV32I integer/compare datapath. Unknown ops
// (including the bubble code) produce a zero result and no branch flag.
module alu_compute
  import alu_exec_unit_pkg::*;
(
  input  logic [5:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] val,
  output logic            is_br
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic [4:0]             shamt;

  assign a_s   = a;
  assign b_s   = b;
  assign shamt = b[4:0];

  // Result select by op; shifts use only the low five bits of b.
  always_comb begin
    val   = '0;
    is_br = 1'b0;
    case (op)
      ALU_ADD:  val = a + b;
      ALU_SUB:  val = a - b;
      ALU_AND:  val = a & b;
      ALU_OR:   val = a | b;
      ALU_XOR:  val = a ^ b;
      ALU_SLL:  val = a << shamt;
      ALU_SRL:  val = a >> shamt;
      ALU_SRA:  val = a_s >>> shamt;
      ALU_SLT:  val = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: val = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_LUI:  val = b;
      ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU: begin
        is_br = 1'b1;
        val   = {{(XLEN-1){1'b0}}, br_taken(op, a_s, b_s)};
      end
      default: begin
        val   = '0;
        is_br = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: samples one dispatched op per enabled cycle and
// broadcasts its result after LATENCY (1 or 2) enabled edges. rdy_in=0
// freezes everything; clear drops all in-flight ops and the one being sampled.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int ROB_W   = ROB_ADDR_W
)(
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  input  logic           clear,
  alu_exec_unit_if.slave bus
);

  // Operands presented to the compute block (dispatch bus or stage1).
  logic             vld_p0;
  logic [5:0]       op_p0;
  logic [XLEN-1:0]  rs1_p0;
  logic [XLEN-1:0]  rs2_p0;
  logic [ROB_W-1:0] id_p0;
  logic [XLEN-1:0]  res_p0;
  logic             br_p0;

  // Broadcast register.
  logic             vld_p2;
  logic [ROB_W-1:0] id_p2;
  logic [XLEN-1:0]  val_p2;
  logic             br_p2;

  generate
    if (LATENCY == 1) begin : g_lat1
      // ---- compute directly on the dispatch bus ----
      assign op_p0  = bus.alu_op;
      assign rs1_p0 = bus.alu_rs1;
      assign rs2_p0 = bus.alu_rs2;
      assign id_p0  = bus.alu_id;
      assign vld_p0 = (bus.alu_op != ALU_NONE);
    end else begin : g_lat2
      logic             vld_p1;
      logic [5:0]       op_p1;
      logic [XLEN-1:0]  rs1_p1;
      logic [XLEN-1:0]  rs2_p1;
      logic [ROB_W-1:0] id_p1;

      // ---- stage1: register dispatch, compute after it ----
      // Stage1 valid: cleared by reset/flush, bubble when op is zero.
      always_ff @(posedge clk_in) begin
        if (rst_in)
          vld_p1 <= 1'b0;
        else if (rdy_in)
          vld_p1 <= !clear && (bus.alu_op != ALU_NONE);
      end

      // Stage1 payload; qualified downstream by vld_p1, so no reset.
      always_ff @(posedge clk_in) begin
        if (rdy_in) begin
          op_p1  <= bus.alu_op;
          rs1_p1 <= bus.alu_rs1;
          rs2_p1 <= bus.alu_rs2;
          id_p1  <= bus.alu_id;
        end
      end

      assign op_p0  = op_p1;
      assign rs1_p0 = rs1_p1;
      assign rs2_p0 = rs2_p1;
      assign id_p0  = id_p1;
      assign vld_p0 = vld_p1;
    end
  endgenerate

  alu_compute u_compute (
    .op    (op_p0),
    .a     (rs1_p0),
    .b     (rs2_p0),
    .val   (res_p0),
    .is_br (br_p0)
  );

  // ---- broadcast register ----
  // Result bus: all fields zero on reset, flush and bubbles so consumers
  // never see stale tags.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vld_p2 <= 1'b0;
      id_p2  <= '0;
      val_p2 <= '0;
      br_p2  <= 1'b0;
    end else if (rdy_in) begin
      if (clear || !vld_p0) begin
        vld_p2 <= 1'b0;
        id_p2  <= '0;
        val_p2 <= '0;
        br_p2  <= 1'b0;
      end else begin
        vld_p2 <= 1'b1;
        id_p2  <= id_p0;
        val_p2 <= res_p0;
        br_p2  <= br_p0;
      end
    end
  end

  assign bus.alu_valid = vld_p2;
  assign bus.alu_robid = id_p2;
  assign bus.alu_val   = val_p2;
  assign bus.alu_is_br = br_p2;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Consumer end of the reservation-station dispatch interface.
- Accepts one dispatched ALU operation per cycle (op, two operands, RoB index), computes the RV32I integer/compare result, and broadcasts it as the alu_valid/alu_robid/alu_val result bus.
- That bus is consumed by the reservation station, load/store buffer and RoB for dependency wake-up and commit.
- Pipelined with configurable latency; supports stall (rdy_in) and speculative flush (clear).

Parameters:
- LATENCY, 1, cycles from dispatch sample to result broadcast; legal values 1 or 2.
- ROB_W, `RoB_addr, width of RoB index.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous active-high reset.
- rdy_in  input  1  global enable; 0 freezes all state.
- clear  input  1  flush (mispredict); drops all in-flight ops.
- alu_op  input  6  dispatched op; `ALU_NONE (0) = bubble.
- alu_rs1  input  32  operand 1.
- alu_rs2  input  32  operand 2 (immediate already substituted by decoder).
- alu_id  input  ROB_W  RoB index of the op.
- alu_valid  output  1  result broadcast valid.
- alu_robid  output  ROB_W  RoB index of broadcast result.
- alu_val  output  32  result value.
- alu_is_br  output  1  broadcast op is a branch compare; alu_val[0] = taken.

Behaviour:
- Reset (rst_in=1 at posedge): alu_valid=0, alu_robid=0, alu_val=0, alu_is_br=0, all pipeline stage valids=0. Reset dominates clear and rdy_in.
- clear=1 at posedge (no reset): all stage valids and alu_valid go to 0. The op sampled on that edge is also discarded. Data fields are don't-care but driven to 0.
- rdy_in=0: all registers hold. Outputs stay constant and inputs are not sampled.
- Sampling: when rdy_in=1, inputs are sampled every posedge.
  - A nonzero alu_op is a valid op; op 0 is a bubble.
  - No backpressure: one op is accepted per cycle.
- Latency:
  - LATENCY=1: the result of an op sampled at edge N appears on outputs after edge N+1 (alu_valid registered; compute is combinational between input and output register).
  - LATENCY=2: stage1 registers op/operands/id at edge N+1; compute happens between stage1 and the output register; the result is visible after edge N+2.
  - Back-to-back ops broadcast in consecutive cycles, in order.
- Bubble: op 0 yields alu_valid=0 in the corresponding output cycle. alu_robid and alu_val are driven to 0 in that cycle.
- Arithmetic: all ops are 32-bit, wrap-around mod 2^32.
  - ADD: a+b. SUB: a-b. AND/OR/XOR: bitwise.
  - SLL: a<<b[4:0]. SRL: logical shift right. SRA: arithmetic shift right. Shift amount is b[4:0] only; upper bits are ignored.
  - SLT: signed less-than, result 1/0. SLTU: unsigned less-than, result 1/0.
  - LUI: result b. AUIPC/JAL link are pre-added by the decoder and arrive as ADD.
- Branch ops (BEQ, BNE, BLT, BGE, BLTU, BGEU): alu_val = {31'b0, taken}, alu_is_br=1. For all other ops alu_is_br=0.
- Unknown nonzero op: broadcast with alu_valid=1, alu_val=0, alu_is_br=0, so the RoB entry is not orphaned.
- Simultaneous clear and valid input: the input is dropped.
- Release after clear: an op sampled on the first edge after clear deasserts is processed normally.

Decomposition:
- const.v holds:
  - op encodings: `ALU_NONE=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, SLL=6, SRL=7, SRA=8, SLT=9, SLTU=10, LUI=11, BEQ=12, BNE=13, BLT=14, BGE=15, BLTU=16, BGEU=17;
  - `RoB_addr.
- One combinational sub-module, alu_compute (op, a, b -> val, is_br), instantiated once. Its position (before or after stage1) is selected by LATENCY via generate.

Test Plan:
- Reset then idle, LATENCY=1: rst_in=1 for 2 cycles, then op=0 -> alu_valid=0, alu_val=0, alu_robid=0 every cycle.
- ADD wrap: op=ADD, rs1=32'hFFFFFFFF, rs2=2, id=5 -> next cycle alu_valid=1, alu_robid=5, alu_val=1, alu_is_br=0.
- Shift/compare:
  - SRA rs1=32'h80000000, rs2=32'h00000024 (amount 4) -> 32'hF8000000.
  - SLT rs1=-1, rs2=1 -> 1.
  - SLTU same operands -> 0.
- Branch: BGEU rs1=3, rs2=7, id=2 -> alu_val=0, alu_is_br=1.
- Branch: BNE rs1=3, rs2=7, id=3 next cycle -> alu_val=1, alu_is_br=1. The two broadcasts are in consecutive cycles.
- Stall/flush, LATENCY=2:
  - dispatch SUB id=1, hold rdy_in=0 for 3 cycles -> outputs frozen, no duplicate broadcast; result 1 appears 2 enabled edges later.
  - dispatch ADD id=4 then assert clear next edge -> id=4 never broadcast.
- Unknown op=6'h3F, id=7 -> alu_valid=1, alu_robid=7, alu_val=0.
